// File: rtl/booth_mul_sink_if.sv
// Operand/product stream bundle for booth_mul_sink.
// The master drives operands and accepts products; the slave is the multiplier.
interface booth_mul_sink_if #(
    parameter int unsigned BOOTH_DATA_IN_WD     = 100,
    parameter int unsigned BOOTH_DATA_IN_VLD_WD = 1,
    parameter int unsigned BOOTH_DATA_IN_RDY_WD = 1
);
    logic [BOOTH_DATA_IN_WD-1:0]     booth_data_in;
    logic [BOOTH_DATA_IN_VLD_WD-1:0] booth_data_in_vld;
    logic [BOOTH_DATA_IN_RDY_WD-1:0] booth_data_in_rdy;
    logic [BOOTH_DATA_IN_WD-1:0]     booth_data_out;
    logic                            booth_data_out_vld;
    logic                            booth_data_out_rdy;

    modport master (
        output booth_data_in,
        output booth_data_in_vld,
        input  booth_data_in_rdy,
        input  booth_data_out,
        input  booth_data_out_vld,
        output booth_data_out_rdy
    );

    modport slave (
        input  booth_data_in,
        input  booth_data_in_vld,
        output booth_data_in_rdy,
        output booth_data_out,
        output booth_data_out_vld,
        input  booth_data_out_rdy
    );
endinterface

// File: rtl/booth_mul_sink.sv
// Sequential radix-4 signed Booth multiplier: one operand pair per handshake,
// one Booth digit per cycle, full-width signed product on a valid/ready output.
module booth_mul_sink #(
    parameter int unsigned BOOTH_DATA_IN_WD     = 100,
    parameter int unsigned BOOTH_DATA_IN_VLD_WD = 1,
    parameter int unsigned BOOTH_DATA_IN_RDY_WD = 1
) (
    input logic             clk,
    input logic             rst_n,
    booth_mul_sink_if.slave bus
);
    localparam int unsigned OP_WD  = BOOTH_DATA_IN_WD / 2;
    localparam int unsigned PR_WD  = 2 * OP_WD;
    localparam int unsigned N_DIG  = OP_WD / 2;
    localparam int unsigned CNT_WD = $clog2(N_DIG + 1);
    localparam logic [CNT_WD-1:0] LAST_CNT = CNT_WD'(N_DIG - 1);

    if (BOOTH_DATA_IN_VLD_WD != 1 || BOOTH_DATA_IN_RDY_WD != 1 ||
        (BOOTH_DATA_IN_WD % 4) != 0 || BOOTH_DATA_IN_WD < 8) begin : g_bad_param
        $error("booth_mul_sink: unsupported parameter set");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e              state_q;
    logic [OP_WD-1:0]    a_q;
    logic [OP_WD-1:0]    b_q;
    logic                prev_q;
    logic [CNT_WD-1:0]   cnt_q;
    logic [PR_WD-1:0]    acc_q;
    logic [PR_WD-1:0]    out_q;
    logic                in_rdy_q;
    logic                out_vld_q;

    logic [PR_WD-1:0]    a_ext;
    logic [PR_WD-1:0]    pp;
    logic [PR_WD-1:0]    acc_nxt;

    // Partial product for the current digit, weighted by 4^cnt; the
    // accumulator wraps modulo 2^PR_WD, which is exact for signed operands.
    always_comb begin
        a_ext = {{(PR_WD - OP_WD){a_q[OP_WD-1]}}, a_q};
        case ({b_q[1:0], prev_q})
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = -(a_ext << 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
        endcase
        acc_nxt = acc_q + (pp << {cnt_q, 1'b0});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.booth_data_in_vld[0] && in_rdy_q) begin
                        a_q      <= bus.booth_data_in[PR_WD-1:OP_WD];
                        b_q      <= bus.booth_data_in[OP_WD-1:0];
                        prev_q   <= 1'b0;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        in_rdy_q <= 1'b0;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q  <= acc_nxt;
                    prev_q <= b_q[1];
                    b_q    <= {{2{b_q[OP_WD-1]}}, b_q[OP_WD-1:2]};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        out_q     <= acc_nxt;
                        out_vld_q <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (bus.booth_data_out_rdy) begin
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.booth_data_in_rdy  = in_rdy_q;
    assign bus.booth_data_out     = out_q;
    assign bus.booth_data_out_vld = out_vld_q;
endmodule

// File: tb/tb_booth_mul_sink.sv
// Directed and random checks of booth_mul_sink against a cycle-level
// behavioural model (signed multiply, fixed latency, one product in flight).
module tb_booth_mul_sink;
    localparam int unsigned WD  = 100;
    localparam int unsigned OP  = WD / 2;
    localparam int          LAT = 25;
    localparam logic [OP-1:0] OP_MIN = 50'h2_0000_0000_0000;
    localparam logic [OP-1:0] OP_MAX = 50'h1_FFFF_FFFF_FFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    booth_mul_sink_if #(
        .BOOTH_DATA_IN_WD    (WD),
        .BOOTH_DATA_IN_VLD_WD(1),
        .BOOTH_DATA_IN_RDY_WD(1)
    ) bus ();

    booth_mul_sink #(
        .BOOTH_DATA_IN_WD    (WD),
        .BOOTH_DATA_IN_VLD_WD(1),
        .BOOTH_DATA_IN_RDY_WD(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    always @(posedge clk) cyc++;

    // Downstream ready: either forced or randomised once per cycle.
    bit rnd_rdy   = 1'b0;
    bit rdy_force = 1'b1;
    bit rnd_bit   = 1'b1;
    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end
    assign bus.booth_data_out_rdy = rnd_rdy ? rnd_bit : rdy_force;

    task automatic check(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WD-1:0] golden(input logic [OP-1:0] a, input logic [OP-1:0] b);
        logic signed [WD-1:0] sa;
        logic signed [WD-1:0] sb;
        sa = WD'($signed(a));
        sb = WD'($signed(b));
        return sa * sb;
    endfunction

    // Behavioural model: busy from accept until output handshake, product
    // valid LAT cycles after accept, output register holds last product.
    bit             busy   = 1'b0;
    int             age    = 0;
    logic [WD-1:0]  exp_p  = '0;
    logic [WD-1:0]  exp_out = '0;
    int             in_hs  = 0;
    int             out_hs = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy    = 1'b0;
            age     = 0;
            exp_out = '0;
            check("rst_in_rdy", bus.booth_data_in_rdy, 1);
            check("rst_out_vld", bus.booth_data_out_vld, 0);
            check("rst_out", bus.booth_data_out, 0);
        end else begin
            if (busy && age == LAT) exp_out = exp_p;
            check("in_rdy", bus.booth_data_in_rdy, !busy);
            check("out_vld", bus.booth_data_out_vld, busy && age >= LAT);
            check("out_data", bus.booth_data_out, exp_out);
            if (busy) begin
                if (age >= LAT && bus.booth_data_out_rdy) begin
                    busy = 1'b0;
                    out_hs++;
                end else begin
                    age++;
                end
            end else if (bus.booth_data_in_vld[0]) begin
                busy  = 1'b1;
                age   = 0;
                exp_p = golden(bus.booth_data_in[WD-1:OP], bus.booth_data_in[OP-1:0]);
                in_hs++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OP-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return OP_MIN;
            1:       return OP_MAX;
            2:       return '0;
            3:       return '1;
            default: return OP'({$urandom(), $urandom()});
        endcase
    endfunction

    // Returns #1 after the accepting edge; hs_cyc is the cycle stamp of it.
    task automatic send(input logic [OP-1:0] a, input logic [OP-1:0] b, input bit rnd_vld,
                        output int hs_cyc);
        int n;
        bit hs;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 400) begin
            bus.booth_data_in_vld = rnd_vld ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.booth_data_in = bus.booth_data_in_vld[0] ? {a, b} : {$urandom(), $urandom(),
                                                                      $urandom(), $urandom()};
            @(negedge clk);
            hs = bus.booth_data_in_vld[0] && bus.booth_data_in_rdy[0];
            tick();
            n++;
        end
        bus.booth_data_in_vld = 1'b0;
        hs_cyc = cyc;
        check("send_timeout", hs, 1);
    endtask

    // Called right after send; ends on the negedge where out_vld is seen.
    task automatic wait_out(output logic [WD-1:0] d, output int lat);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            if (bus.booth_data_out_vld) break;
            @(posedge clk);
            lat++;
        end
        d = bus.booth_data_out;
        check("out_timeout", lat < 200, 1);
    endtask

    task automatic directed(input string name, input logic [OP-1:0] a, input logic [OP-1:0] b,
                            input logic [WD-1:0] expv);
        logic [WD-1:0] d;
        int lat;
        int t;
        send(a, b, 1'b0, t);
        wait_out(d, lat);
        check(name, d, expv);
        check({name, "_latency"}, lat, LAT);
        tick();
        tick();
    endtask

    initial begin
        logic [WD-1:0] d;
        int lat;
        int t;
        int t_prev;

        bus.booth_data_in     = '0;
        bus.booth_data_in_vld = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        directed("a3_b5", 50'd3, 50'd5, 100'd15);
        directed("neg1_x_1", '1, 50'd1, {WD{1'b1}});
        directed("m7_x_m6", -50'sd7, -50'sd6, 100'd42);
        directed("min_x_min", OP_MIN, OP_MIN, 100'h4_0000_0000_0000_0000_0000_0000);
        directed("max_x_min", OP_MAX, OP_MIN, 100'hC_0000_0000_0002_0000_0000_0000);
        directed("zero_x_rand", '0, 50'h1_2345_6789_ABCD, 100'd0);

        // Back-pressure: hold the product for 10 cycles.
        rdy_force = 1'b0;
        send(50'd1000, -50'sd3, 1'b0, t);
        wait_out(d, lat);
        check("bp_data", d, {{70{1'b1}}, 30'h3FFF_F448});
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("bp_hold_data", bus.booth_data_out, d);
            check("bp_hold_in_rdy", bus.booth_data_in_rdy, 0);
        end
        tick();
        rdy_force = 1'b1;
        tick();
        @(negedge clk);
        check("bp_release_vld", bus.booth_data_out_vld, 0);
        check("bp_release_in_rdy", bus.booth_data_in_rdy, 1);
        tick();

        // Back-to-back stream with in_vld held high.
        t_prev = 0;
        for (int i = 0; i < 20; i++) begin
            send(rand_op(), rand_op(), 1'b0, t);
            if (i > 0) check("stream_gap", t - t_prev, LAT + 2);
            t_prev = t;
        end
        repeat (LAT + 4) tick();
        check("stream_count", out_hs, in_hs);

        // Reset in the middle of CALC, then a normal transaction.
        send(50'd7, 50'd9, 1'b0, t);
        repeat (10) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_rdy", bus.booth_data_in_rdy, 1);
        tick();
        directed("after_rst_2x2", 50'd2, 50'd2, 100'd4);
        repeat (LAT + 4) tick();
        check("no_stale_vld", bus.booth_data_out_vld, 0);

        // Random valid/ready toggling.
        in_hs  = 0;
        out_hs = 0;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) send(rand_op(), rand_op(), 1'b1, t);
        rnd_rdy = 1'b0;
        repeat (LAT + 6) tick();
        check("random_count", out_hs, in_hs);
        check("random_total", in_hs, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end
endmodule
